// File: rtl/pifo_pop_monitor.sv
// Pop-side initiator/checker for a PIFO: tracks occupancy, issues spaced pops, captures and order-checks pop data.
// Latency: o_pop -> i_pop_data after POP_LAT cycles; o_pop -> o_data_valid after POP_LAT+1 cycles.
// Backpressure: a pending pop is held off (o_pop low) in any cycle where i_push is high; no downstream stall.
//
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_push                push strobe observed on the PIFO push port
//   i_pop_en, i_drain_req single-pop / drain-all request pulses
//   o_pop                 pop strobe to the PIFO
//   i_pop_data            PIFO pop data, valid POP_LAT cycles after o_pop
//   o_data_valid, o_data  captured pop data (1-cycle pulse)
//   o_occupancy           entries currently held by the PIFO
//   o_busy                sequencer not idle
//   o_pop_cnt             wrapping count of pops issued
//   o_order_err, o_ovf_err, o_unf_err  sticky error flags, cleared by reset only
//
// POP_GAP is expected to be >= 1.
module pifo_pop_monitor #(
    parameter int PTW     = 10,
    parameter int MTW     = 0,
    parameter int CAP     = 24,
    parameter int POP_LAT = 1,
    parameter int POP_GAP = 2,
    parameter int CNT_W   = 16,
    localparam int DW     = PTW + MTW,
    localparam int OCC_W  = $clog2(CAP + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop_en,
    input  logic             i_drain_req,
    output logic             o_pop,
    input  logic [DW-1:0]    i_pop_data,
    output logic             o_data_valid,
    output logic [DW-1:0]    o_data,
    output logic [OCC_W-1:0] o_occupancy,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_pop_cnt,
    output logic             o_order_err,
    output logic             o_ovf_err,
    output logic             o_unf_err
);

    localparam int GAP_W = (POP_GAP > 0) ? $clog2(POP_GAP + 1) : 1;
    localparam logic [OCC_W-1:0] CAP_OCC = OCC_W'(CAP);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, FLUSH} state_t;

    state_t             state;
    logic               drain;
    logic [GAP_W-1:0]   gap_cnt;
    logic [POP_LAT-1:0] pipe;
    logic [PTW-1:0]     ref_rank;
    logic               ref_valid;
    logic [PTW-1:0]     pop_rank;
    logic               pipe_tail;
    logic               drain_next;

    // A push and a pop never share a cycle: the PIFO cannot do both at once.
    assign o_pop      = (state == ISSUE) && !i_push;
    assign o_busy     = (state != IDLE);
    assign pop_rank   = i_pop_data[DW-1:MTW];
    assign pipe_tail  = pipe[POP_LAT-1];
    // A drain request arriving on the decision cycle still extends the run.
    assign drain_next = drain || i_drain_req;

    // Occupancy tracking and pop sequencer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            drain       <= 1'b0;
            gap_cnt     <= '0;
            o_occupancy <= '0;
            o_pop_cnt   <= '0;
            o_ovf_err   <= 1'b0;
            o_unf_err   <= 1'b0;
        end else begin
            if (i_push) begin
                if (o_occupancy == CAP_OCC) begin
                    o_ovf_err <= 1'b1;
                end else begin
                    o_occupancy <= o_occupancy + 1'b1;
                end
            end else if (o_pop) begin
                o_occupancy <= o_occupancy - 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_pop_en || i_drain_req) begin
                        if (o_occupancy == '0) begin
                            o_unf_err <= 1'b1;
                        end else begin
                            drain <= i_drain_req;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (i_drain_req) begin
                        drain <= 1'b1;
                    end
                    if (!i_push) begin
                        o_pop_cnt <= o_pop_cnt + 1'b1;
                        gap_cnt   <= GAP_W'(POP_GAP);
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (i_drain_req) begin
                        drain <= 1'b1;
                    end
                    // Decide on the cycle the counter reaches zero so that exactly
                    // POP_GAP idle cycles separate consecutive pops.
                    if (gap_cnt <= GAP_W'(1)) begin
                        gap_cnt <= '0;
                        if (drain_next && (o_occupancy != '0)) begin
                            state <= ISSUE;
                        end else begin
                            state <= FLUSH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                FLUSH: begin
                    if (pipe == '0) begin
                        state <= IDLE;
                        drain <= 1'b0;
                    end else if (i_drain_req) begin
                        drain <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Pop latency pipe, data capture and ordering check.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pipe         <= '0;
            o_data_valid <= 1'b0;
            o_data       <= '0;
            o_order_err  <= 1'b0;
            ref_rank     <= '0;
            ref_valid    <= 1'b0;
        end else begin
            pipe[0] <= o_pop;
            for (int i = 1; i < POP_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end

            o_data_valid <= pipe_tail;
            if (pipe_tail) begin
                o_data <= i_pop_data;
                if (ref_valid && (pop_rank < ref_rank)) begin
                    o_order_err <= 1'b1;
                end
                ref_rank  <= pop_rank;
                ref_valid <= 1'b1;
            end

            // A newly pushed entry may legitimately outrank everything popped so far.
            if (i_push) begin
                ref_valid <= 1'b0;
            end
        end
    end

endmodule
